// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: instruction classes, major opcodes, immediate limits.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package riscv_pkg;

  // Instruction classes understood by the encoder; codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    CLS_LOAD   = 3'd0,
    CLS_STORE  = 3'd1,
    CLS_RTYPE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_ITYPE  = 3'd4,
    CLS_JAL    = 3'd5
  } instr_cls_e;

  // Major opcodes, bits [6:0] of the instruction word.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Signed immediate limits per format. B and J offsets must also be even.
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;
  localparam int SHAMT_MAX = 31;

  // True for the six defined class codes.
  function automatic logic cls_legal(input logic [2:0] c);
    return c <= 3'd5;
  endfunction

endpackage

// File: rtl/imm_encoder.sv
// Places a signed immediate into its RV32I bit positions for a class and checks its range.
// Latency: purely combinational.
// Backpressure: not applicable; caller qualifies the result with its own handshake.
module imm_encoder
  import riscv_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic        is_shift,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        range_ok
);

  logic signed [31:0] simm;
  assign simm = $signed(imm);

  // Scatter immediate bits per format; everything outside the immediate fields stays zero.
  always_comb begin
    imm_bits = '0;
    range_ok = 1'b0;
    case (cls)
      CLS_LOAD: begin
        imm_bits[31:20] = imm[11:0];
        range_ok        = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
      end
      CLS_ITYPE: begin
        if (is_shift) begin
          // Shift-immediate forms carry only a 5-bit shamt; funct7 fills [31:25] upstream.
          imm_bits[24:20] = imm[4:0];
          range_ok        = (simm >= 0) && (simm <= SHAMT_MAX);
        end else begin
          imm_bits[31:20] = imm[11:0];
          range_ok        = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
        end
      end
      CLS_STORE: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        range_ok        = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
      end
      CLS_BRANCH: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        range_ok        = (simm >= IMM13_MIN) && (simm <= IMM13_MAX) && !imm[0];
      end
      CLS_JAL: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        range_ok        = (simm >= IMM21_MIN) && (simm <= IMM21_MAX) && !imm[0];
      end
      CLS_RTYPE: begin
        // No immediate; any value is acceptable and ignored.
        range_ok = 1'b1;
      end
      default: begin
        imm_bits = '0;
        range_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field-level requests into RV32I words tagged with a running word address.
// Latency: request accepted at edge N is visible on out_valid/out_instr right after edge N.
// Backpressure: in_ready is purely occupancy-based (< DEPTH); a full buffer blocks input even on a same-cycle dequeue.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_cls,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Output buffer state
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      addr_mem_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  // Address counter and error reporting
  logic [31:0] addr_q, addr_d, slot_addr;
  logic        err_q;
  logic [7:0]  err_count_q;

  // Request decode
  logic        is_shift;
  logic [31:0] imm_bits;
  logic        range_ok;
  logic [31:0] word_d;
  logic        legal, accept, enq, rej, deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // funct3 001 (slli) and 101 (srli/srai) take a shamt instead of a 12-bit immediate.
  assign is_shift = (in_cls == CLS_ITYPE) && (in_funct3[1:0] == 2'b01);

  imm_encoder u_imm_encoder (
    .cls      (in_cls),
    .is_shift (is_shift),
    .imm      (in_imm),
    .imm_bits (imm_bits),
    .range_ok (range_ok)
  );

  // Merge register/function fields and opcode with the placed immediate; unused fields encode zero.
  always_comb begin
    word_d = '0;
    case (in_cls)
      CLS_LOAD:   word_d = imm_bits | {12'b0, in_rs1, in_funct3, in_rd, OPC_LOAD};
      CLS_STORE:  word_d = imm_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, OPC_STORE};
      CLS_RTYPE:  word_d = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_RTYPE};
      CLS_BRANCH: word_d = imm_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, OPC_BRANCH};
      CLS_ITYPE:  word_d = imm_bits | {(is_shift ? in_funct7 : 7'b0), 5'b0, in_rs1, in_funct3,
                                       in_rd, OPC_ITYPE};
      CLS_JAL:    word_d = imm_bits | {20'b0, in_rd, OPC_JAL};
      default:    word_d = '0;
    endcase
  end

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_instr = instr_mem_q[rd_ptr_q];
  assign out_addr  = addr_mem_q[rd_ptr_q];
  assign err       = err_q;
  assign err_count = err_count_q;

  assign legal  = cls_legal(in_cls) && range_ok;
  assign accept = in_valid && in_ready;
  assign enq    = accept && legal;
  assign rej    = accept && !legal;
  assign deq    = out_valid && out_ready;

  // A same-cycle clear takes effect before the accepted request picks its address.
  always_comb begin
    slot_addr = clr_addr ? BASE_ADDR : addr_q;
    addr_d    = enq ? (slot_addr + 32'd4) : slot_addr;
  end

  // Occupancy moves only when exactly one of enqueue/dequeue fires.
  always_comb begin
    count_d = count_q;
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Buffer storage and pointers: writes land at the tail, reads advance the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        addr_mem_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        instr_mem_q[wr_ptr_q] <= word_d;
        addr_mem_q[wr_ptr_q]  <= slot_addr;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (deq) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  // Word address counter; rejected requests leave it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= BASE_ADDR;
    end else begin
      addr_q <= addr_d;
    end
  end

  // One-cycle error pulse and saturating reject counter; immune to clr_addr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q <= rej;
      if (rej && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed instruction words.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: exercised by holding out_ready low with the buffer full.
module tb_instr_encoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clr_addr, in_valid, in_ready;
  logic [2:0]  in_cls, in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, err;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .clr_addr  (clr_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cls    (in_cls),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .err_count (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_cls    = 3'd0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_funct3 = '0;
    in_funct7 = '0;
    in_imm    = '0;
  endtask

  task automatic req(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm);
    in_valid  = 1'b1;
    in_cls    = cls;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic do_reset();
    idle();
    clr_addr = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    clr_addr  = 1'b0;
    out_ready = 1'b0;
    idle();
    tick();
    tick();
    // State while reset is held
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", out_addr, 0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // LOAD x5, 8(x2)
    out_ready = 1'b1;
    req(CLS_LOAD, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
    tick();
    idle();
    chk("load_valid", out_valid, 1);
    chk("load_instr", out_instr, 32'h0081_2283);
    chk("load_addr", out_addr, 32'h0);

    // JAL x1, 2048 while LOAD dequeues: occupancy unchanged
    req(CLS_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    chk("jal_instr", out_instr, 32'h0010_00EF);
    chk("jal_addr", out_addr, 32'h4);

    // JAL with odd offset is rejected
    req(CLS_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick();
    chk("jal_odd_err", err, 1);
    chk("jal_odd_count", err_count, 1);
    chk("jal_odd_noout", out_valid, 0);

    // RTYPE add x3,x1,x2 with junk immediate gets the next address 0x8
    req(CLS_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h1234_5678);
    tick();
    idle();
    chk("err_one_cycle", err, 0);
    chk("rtype_instr", out_instr, 32'h0020_81B3);
    chk("rtype_addr", out_addr, 32'h8);
    tick();
    chk("drain_empty", out_valid, 0);

    // STORE then BRANCH from a fresh reset
    do_reset();
    out_ready = 1'b1;
    req(CLS_STORE, 5'd0, 5'd2, 5'd6, 3'b010, 7'd0, 32'd12);
    tick();
    chk("store_instr", out_instr, 32'h0061_2623);
    chk("store_addr", out_addr, 32'h0);
    req(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4);
    tick();
    chk("branch_instr", out_instr, 32'hFE20_8EE3);
    chk("branch_addr", out_addr, 32'h4);

    // Range boundaries and illegal class
    req(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3);
    tick();
    chk("branch_odd_err", err, 1);
    chk("branch_odd_count", err_count, 1);
    req(CLS_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4096);
    tick();
    chk("branch_hi_count", err_count, 2);
    req(CLS_LOAD, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048);
    tick();
    chk("load_hi_err", err, 1);
    chk("load_hi_count", err_count, 3);
    req(3'd6, 5'd1, 5'd1, 5'd1, 3'b000, 7'd0, 32'd0);
    tick();
    chk("cls6_count", err_count, 4);
    chk("cls6_noout", out_valid, 0);
    req(CLS_LOAD, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2048);
    tick();
    idle();
    chk("load_min_instr", out_instr, 32'h8000_0003);
    chk("load_min_addr", out_addr, 32'h8);
    chk("load_min_err", err, 0);
    tick();

    // Backpressure: three requests offered, only two fit
    do_reset();
    out_ready = 1'b0;
    req(CLS_LOAD, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    req(CLS_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_head_instr", out_instr, 32'h0000_0083);
    req(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1);
    tick();
    chk("bp_still_full", in_ready, 0);
    chk("bp_hold_instr", out_instr, 32'h0000_0083);
    chk("bp_hold_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("bp_second_instr", out_instr, 32'h0020_81B3);
    chk("bp_second_addr", out_addr, 32'h4);
    chk("bp_ready_again", in_ready, 1);
    tick();
    idle();
    chk("bp_third_instr", out_instr, 32'hFFF0_0093);
    chk("bp_third_addr", out_addr, 32'h8);
    tick();
    chk("bp_drained", out_valid, 0);

    // Shift immediates, address clear
    do_reset();
    out_ready = 1'b1;
    req(CLS_ITYPE, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd32);
    tick();
    chk("shamt_err", err, 1);
    chk("shamt_count", err_count, 1);
    chk("shamt_noout", out_valid, 0);
    req(CLS_ITYPE, 5'd2, 5'd3, 5'd0, 3'b101, 7'h20, 32'd5);
    tick();
    chk("srai_instr", out_instr, 32'h4051_D113);
    chk("srai_addr", out_addr, 32'h0);
    req(CLS_LOAD, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    chk("pre_clr_addr", out_addr, 32'h4);
    clr_addr = 1'b1;
    req(CLS_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    clr_addr = 1'b0;
    chk("clr_same_addr", out_addr, 32'h0);
    chk("clr_keeps_count", err_count, 1);
    req(CLS_ITYPE, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1);
    tick();
    chk("after_clr_addr", out_addr, 32'h4);
    idle();
    clr_addr = 1'b1;
    tick();
    clr_addr = 1'b0;
    chk("clr_keeps_entry", out_valid, 0);
    req(CLS_LOAD, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    chk("clr_idle_addr", out_addr, 32'h0);

    // Reject counter saturates at 255
    for (int i = 0; i < 260; i++) begin
      req(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      tick();
    end
    idle();
    chk("sat_count", err_count, 8'd255);
    tick();

    // Asynchronous reset with the buffer full
    out_ready = 1'b0;
    req(CLS_LOAD, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    req(CLS_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    idle();
    chk("pre_rst_full", in_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_count", err_count, 0);
    chk("async_rst_instr", out_instr, 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    req(CLS_LOAD, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    idle();
    chk("post_rst_addr", out_addr, 32'h0);
    chk("post_rst_err", err, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
